// File: rtl/ifetcher.sv
// Instruction fetch stage: PC, direct-mapped icache with memory-controller refill,
// 2-bit BHT branch prediction, one registered instruction per cycle to issue.
module ifetcher #(
  parameter int unsigned ICACHE_LINES = 16,
  parameter int unsigned BHT_SIZE     = 64,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ROB_full,
  input  logic        RS_full,
  input  logic        LSB_full,
  input  logic        ROB_clear,
  input  logic [31:0] ROB_newpc,
  input  logic        ROB_br_sgn,
  input  logic [31:0] ROB_br_pc,
  input  logic        ROB_br_taken,
  output logic        MC_sgn,
  output logic [31:0] MC_addr,
  input  logic        MC_done,
  input  logic [31:0] MC_ins,
  output logic        IF_ins_sgn,
  output logic [31:0] IF_ins,
  output logic        IF_jump_flag,
  output logic [31:0] IF_jump_pc
);

  localparam int unsigned IdxW = $clog2(ICACHE_LINES);
  localparam int unsigned TagW = 32 - IdxW - 2;
  localparam int unsigned BhtW = $clog2(BHT_SIZE);

  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [1:0] {StFetch, StMiss, StJwait} state_e;

  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d;

  logic [ICACHE_LINES-1:0] valid_q;
  logic [TagW-1:0]         tag_q  [ICACHE_LINES];
  logic [31:0]             data_q [ICACHE_LINES];
  logic [1:0]              bht_q  [BHT_SIZE];

  logic [IdxW-1:0] line_idx;
  logic [TagW-1:0] line_tag;
  logic            hit, stall, fill;
  logic [31:0]     cur_ins, imm_j, imm_b, pc_plus4;
  logic [31:0]     dec_next_pc, dec_jump_pc;
  logic            dec_flag, dec_jalr;
  logic [BhtW-1:0] bht_rd_idx, bht_wr_idx;
  logic            predict_taken;
  logic [1:0]      bht_ctr, bht_upd;

  logic        ins_sgn_d, jump_flag_d, mc_sgn_d;
  logic [31:0] ins_d, jump_pc_d, mc_addr_d;

  logic unused_br_pc;
  assign unused_br_pc = ^{ROB_br_pc[31:BhtW+2], ROB_br_pc[1:0]};

  assign line_idx      = pc_q[IdxW+1:2];
  assign line_tag      = pc_q[31:IdxW+2];
  assign hit           = valid_q[line_idx] && (tag_q[line_idx] == line_tag);
  assign cur_ins       = data_q[line_idx];
  assign stall         = ROB_full | RS_full | LSB_full;
  assign pc_plus4      = pc_q + 32'd4;
  assign imm_j         = {{12{cur_ins[31]}}, cur_ins[19:12], cur_ins[20], cur_ins[30:21], 1'b0};
  assign imm_b         = {{20{cur_ins[31]}}, cur_ins[7], cur_ins[30:25], cur_ins[11:8], 1'b0};
  assign bht_rd_idx    = pc_q[BhtW+1:2];
  assign bht_wr_idx    = ROB_br_pc[BhtW+1:2];
  assign predict_taken = bht_q[bht_rd_idx][1];

  // Next PC and the auxiliary PC handed to issue; AUIPC and plain ops share the default.
  always_comb begin
    dec_next_pc = pc_plus4;
    dec_jump_pc = pc_q;
    dec_flag    = 1'b0;
    dec_jalr    = 1'b0;
    case (cur_ins[6:0])
      OpJal: begin
        dec_next_pc = pc_q + imm_j;
        dec_jump_pc = pc_plus4;
      end
      OpBranch: begin
        if (predict_taken) begin
          dec_next_pc = pc_q + imm_b;
          dec_jump_pc = pc_plus4;
          dec_flag    = 1'b1;
        end else begin
          dec_jump_pc = pc_q + imm_b;
        end
      end
      OpJalr: begin
        dec_next_pc = pc_q;
        dec_jump_pc = pc_plus4;
        dec_jalr    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    bht_ctr = bht_q[bht_wr_idx];
    bht_upd = bht_ctr;
    if (ROB_br_taken && (bht_ctr != 2'b11)) begin
      bht_upd = bht_ctr + 2'b01;
    end else if (!ROB_br_taken && (bht_ctr != 2'b00)) begin
      bht_upd = bht_ctr - 2'b01;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ins_sgn_d   = 1'b0;
    ins_d       = IF_ins;
    jump_flag_d = IF_jump_flag;
    jump_pc_d   = IF_jump_pc;
    mc_sgn_d    = MC_sgn;
    mc_addr_d   = MC_addr;
    fill        = 1'b0;
    if (ROB_clear) begin
      // Dropping the request aborts any in-flight refill; a same-cycle MC_done is discarded.
      pc_d     = ROB_newpc;
      state_d  = StFetch;
      mc_sgn_d = 1'b0;
    end else begin
      case (state_q)
        StFetch: begin
          if (hit) begin
            if (!stall) begin
              ins_sgn_d   = 1'b1;
              ins_d       = cur_ins;
              jump_flag_d = dec_flag;
              jump_pc_d   = dec_jump_pc;
              pc_d        = dec_next_pc;
              if (dec_jalr) state_d = StJwait;
            end
          end else begin
            mc_sgn_d  = 1'b1;
            mc_addr_d = {pc_q[31:2], 2'b00};
            state_d   = StMiss;
          end
        end
        StMiss: begin
          if (MC_done) begin
            fill     = 1'b1;
            mc_sgn_d = 1'b0;
            state_d  = StFetch;
          end
        end
        StJwait: ;
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      IF_ins_sgn   <= 1'b0;
      IF_ins       <= 32'h0;
      IF_jump_flag <= 1'b0;
      IF_jump_pc   <= 32'h0;
      MC_sgn       <= 1'b0;
      MC_addr      <= 32'h0;
      valid_q      <= '0;
      bht_q        <= '{default: 2'b01};
    end else if (rdy) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      IF_ins_sgn   <= ins_sgn_d;
      IF_ins       <= ins_d;
      IF_jump_flag <= jump_flag_d;
      IF_jump_pc   <= jump_pc_d;
      MC_sgn       <= mc_sgn_d;
      MC_addr      <= mc_addr_d;
      if (fill) begin
        valid_q[line_idx] <= 1'b1;
        tag_q[line_idx]   <= line_tag;
        data_q[line_idx]  <= MC_ins;
      end
      if (ROB_br_sgn) bht_q[bht_wr_idx] <= bht_upd;
    end
  end

endmodule

// File: tb/tb_ifetcher.sv
// Bench for ifetcher: directed opcode table, hand-written corner sequences, then random
// traffic against a cycle-level reference model of the fetch stage.
module tb_ifetcher;
  localparam int unsigned Lines = 16;
  localparam int unsigned Bht   = 64;
  localparam int unsigned MemW  = 1024;
  localparam int KOther = 0, KAuipc = 1, KJal = 2, KBr = 3, KJalr = 4;
  localparam int MFetch = 0, MMiss = 1, MJwait = 2;

  logic clk = 1'b0;
  logic rst, rdy, ROB_full, RS_full, LSB_full, ROB_clear, ROB_br_sgn, ROB_br_taken, MC_done;
  logic [31:0] ROB_newpc, ROB_br_pc, MC_ins;
  logic MC_sgn, IF_ins_sgn, IF_jump_flag;
  logic [31:0] MC_addr, IF_ins, IF_jump_pc;

  always #5 clk = ~clk;

  ifetcher #(.ICACHE_LINES(Lines), .BHT_SIZE(Bht), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .ROB_full(ROB_full), .RS_full(RS_full),
    .LSB_full(LSB_full), .ROB_clear(ROB_clear), .ROB_newpc(ROB_newpc),
    .ROB_br_sgn(ROB_br_sgn), .ROB_br_pc(ROB_br_pc), .ROB_br_taken(ROB_br_taken),
    .MC_sgn(MC_sgn), .MC_addr(MC_addr), .MC_done(MC_done), .MC_ins(MC_ins),
    .IF_ins_sgn(IF_ins_sgn), .IF_ins(IF_ins), .IF_jump_flag(IF_jump_flag),
    .IF_jump_pc(IF_jump_pc)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    int          ntk;
    int          nnt;
    logic        flag;
    logic [31:0] jpc;
    logic [31:0] nxt;
    logic        jwait;
  } vec_t;
  vec_t vecs[10];

  // Program image for the random phase: what each word is, and its immediate.
  int          kind [MemW];
  logic [31:0] pimm [MemW];
  logic [31:0] imem [MemW];

  logic [31:0] m_pc, m_ins, m_jpc, m_mca;
  logic [31:0] m_tag [Lines];
  logic [31:0] m_data [Lines];
  logic        m_valid [Lines];
  int          m_bht [Bht];
  int          m_mode;
  logic        m_sgn, m_flag, m_mcs;

  function automatic logic [31:0] enc_jal(input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_jalr();
    return {12'h0, 5'd1, 3'b000, 5'd0, 7'b1100111};
  endfunction
  function automatic logic [31:0] enc_auipc();
    return {20'h12345, 5'd2, 7'b0010111};
  endfunction
  function automatic logic [31:0] enc_addi(input logic [11:0] imm);
    return {imm, 5'd3, 3'b000, 5'd3, 7'b0010011};
  endfunction
  function automatic int unsigned widx(input logic [31:0] a);
    return (a / 4) % MemW;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_mc(input string name);
    int n = 0;
    while (!MC_sgn && n < 20) begin
      tick();
      n++;
    end
    check(name, MC_sgn, 1);
  endtask

  task automatic serve(input logic [31:0] addr, input logic [31:0] ins, input int lat);
    wait_mc("req_seen");
    check("req_addr", MC_addr, addr);
    repeat (lat) tick();
    MC_done = 1'b1;
    MC_ins  = ins;
    tick();
    MC_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    logic seen;
    do_reset();
    for (int i = 0; i < v.ntk + v.nnt; i++) begin
      ROB_br_sgn   = 1'b1;
      ROB_br_pc    = v.pc;
      ROB_br_taken = (i < v.ntk);
      tick();
    end
    ROB_br_sgn = 1'b0;
    ROB_clear  = 1'b1;
    ROB_newpc  = v.pc;
    tick();
    ROB_clear = 1'b0;
    serve(v.pc, v.ins, 0);
    n = 0;
    while (!IF_ins_sgn && n < 5) begin
      tick();
      n++;
    end
    check("fill_to_emit", n, 1);
    check("vec_ins", IF_ins, v.ins);
    check("vec_flag", IF_jump_flag, v.flag);
    check("vec_jump_pc", IF_jump_pc, v.jpc);
    if (v.jwait) begin
      seen = 1'b0;
      repeat (6) begin
        tick();
        seen = seen | IF_ins_sgn | MC_sgn;
      end
      check("jwait_quiet", seen, 0);
      ROB_clear = 1'b1;
      ROB_newpc = 32'h100;
      tick();
      ROB_clear = 1'b0;
      tick();
      check("jwait_redirect", {MC_sgn, MC_addr}, {1'b1, 32'h100});
    end else begin
      wait_mc("next_seen");
      check("vec_next_pc", MC_addr, v.nxt);
    end
  endtask

  task automatic model_step();
    logic [31:0] idx, tg, b;
    int unsigned w;
    logic taken;
    if (!rst) begin
      m_pc = 32'h0; m_mode = MFetch; m_sgn = 0; m_ins = 0; m_flag = 0; m_jpc = 0;
      m_mcs = 0; m_mca = 0;
      for (int i = 0; i < Lines; i++) m_valid[i] = 1'b0;
      for (int i = 0; i < Bht; i++) m_bht[i] = 1;
    end else if (rdy) begin
      idx   = (m_pc / 4) % Lines;
      tg    = m_pc / (4 * Lines);
      w     = widx(m_pc);
      taken = (m_bht[(m_pc / 4) % Bht] >= 2);
      m_sgn = 1'b0;
      if (ROB_clear) begin
        m_pc = ROB_newpc; m_mode = MFetch; m_mcs = 1'b0;
      end else if (m_mode == MFetch) begin
        if (m_valid[idx] && m_tag[idx] == tg) begin
          if (!(ROB_full || RS_full || LSB_full)) begin
            m_sgn = 1'b1; m_ins = m_data[idx]; m_flag = 1'b0; m_jpc = m_pc;
            if (kind[w] == KJal) begin
              m_jpc = m_pc + 4; m_pc = m_pc + pimm[w];
            end else if (kind[w] == KBr && taken) begin
              m_flag = 1'b1; m_jpc = m_pc + 4; m_pc = m_pc + pimm[w];
            end else if (kind[w] == KBr) begin
              m_jpc = m_pc + pimm[w]; m_pc = m_pc + 4;
            end else if (kind[w] == KJalr) begin
              m_jpc = m_pc + 4; m_mode = MJwait;
            end else begin
              m_pc = m_pc + 4;
            end
          end
        end else begin
          m_mcs = 1'b1; m_mca = m_pc & 32'hFFFF_FFFC; m_mode = MMiss;
        end
      end else if (m_mode == MMiss && MC_done) begin
        m_valid[idx] = 1'b1; m_tag[idx] = tg; m_data[idx] = MC_ins;
        m_mcs = 1'b0; m_mode = MFetch;
      end
      if (ROB_br_sgn) begin
        b = (ROB_br_pc / 4) % Bht;
        if (ROB_br_taken) m_bht[b] = (m_bht[b] == 3) ? 3 : m_bht[b] + 1;
        else              m_bht[b] = (m_bht[b] == 0) ? 0 : m_bht[b] - 1;
      end
    end
  endtask

  initial begin
    logic [31:0] a0, a4, a8;
    int wcnt, lat, r, off;

    vecs[0] = '{32'h10, enc_b(32'h20), 0, 0, 1'b0, 32'h30, 32'h14, 1'b0};
    vecs[1] = '{32'h10, enc_b(32'h20), 2, 0, 1'b1, 32'h14, 32'h30, 1'b0};
    vecs[2] = '{32'h40, enc_jal(32'hFFFF_FFC0), 0, 0, 1'b0, 32'h44, 32'h0, 1'b0};
    vecs[3] = '{32'h8, enc_jalr(), 0, 0, 1'b0, 32'hC, 32'h0, 1'b1};
    vecs[4] = '{32'h20, enc_auipc(), 0, 0, 1'b0, 32'h20, 32'h24, 1'b0};
    vecs[5] = '{32'h24, enc_addi(12'h7FF), 0, 0, 1'b0, 32'h24, 32'h28, 1'b0};
    vecs[6] = '{32'h200, enc_b(32'hFFFF_FFF8), 1, 0, 1'b1, 32'h204, 32'h1F8, 1'b0};
    vecs[7] = '{32'h60, enc_b(32'h10), 4, 1, 1'b1, 32'h64, 32'h70, 1'b0};
    vecs[8] = '{32'h80, enc_b(32'h100), 0, 1, 1'b0, 32'h180, 32'h84, 1'b0};
    vecs[9] = '{32'hFFFF_FFFC, enc_jal(32'h8), 0, 0, 1'b0, 32'h0, 32'h4, 1'b0};

    rst = 1'b0; rdy = 1'b1; ROB_full = 0; RS_full = 0; LSB_full = 0; ROB_clear = 0;
    ROB_newpc = 0; ROB_br_sgn = 0; ROB_br_pc = 0; ROB_br_taken = 0; MC_done = 0; MC_ins = 0;
    tick();
    tick();
    check("reset_outputs", {IF_ins_sgn, IF_ins, IF_jump_flag, IF_jump_pc, MC_sgn, MC_addr}, 0);
    rst = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Cold start, then a hit loop with a three-cycle RS_full stall in the middle.
    a0 = enc_addi(12'h001); a4 = enc_addi(12'h002); a8 = enc_addi(12'h003);
    do_reset();
    serve(32'h0, a0, 3);
    serve(32'h4, a4, 3);
    serve(32'h8, a8, 3);
    wait_mc("cold_c_seen");
    check("cold_c_addr", MC_addr, 32'hC);
    ROB_clear = 1'b1; ROB_newpc = 32'h0;
    tick();
    ROB_clear = 1'b0;
    tick();
    check("hit0", {IF_ins_sgn, IF_ins}, {1'b1, a0});
    tick();
    check("hit4", {IF_ins_sgn, IF_ins}, {1'b1, a4});
    RS_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_quiet", {IF_ins_sgn, MC_sgn}, 0);
    end
    RS_full = 1'b0;
    tick();
    check("stall_resume", {IF_ins_sgn, IF_ins}, {1'b1, a8});

    // Redirect coinciding with refill completion must not fill the line.
    do_reset();
    wait_mc("abort_seen");
    MC_done = 1'b1; MC_ins = 32'hDEAD_BEEF; ROB_clear = 1'b1; ROB_newpc = 32'h100;
    tick();
    MC_done = 1'b0; ROB_clear = 1'b0;
    check("abort_drop", {MC_sgn, IF_ins_sgn}, 0);
    tick();
    check("abort_refetch", {MC_sgn, MC_addr}, {1'b1, 32'h100});
    serve(32'h100, a4, 1);
    tick();
    check("abort_new_hit", {IF_ins_sgn, IF_ins}, {1'b1, a4});
    ROB_clear = 1'b1; ROB_newpc = 32'h0;
    tick();
    ROB_clear = 1'b0;
    tick();
    check("abort_no_fill", {IF_ins_sgn, MC_sgn, MC_addr}, {1'b0, 1'b1, 32'h0});

    // Reset in the middle of a refill.
    do_reset();
    serve(32'h0, a8, 1);
    tick();
    check("pre_reset_emit", {IF_ins_sgn, IF_ins}, {1'b1, a8});
    wait_mc("pre_reset_miss");
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_miss_reset", {IF_ins_sgn, IF_ins, IF_jump_flag, IF_jump_pc, MC_sgn, MC_addr}, 0);
    tick();
    check("reset_invalidates", {IF_ins_sgn, MC_sgn, MC_addr}, {1'b0, 1'b1, 32'h0});

    // Random program and traffic against the reference model.
    for (int w = 0; w < MemW; w++) begin
      r   = $urandom % 100;
      off = int'($urandom_range(0, 32)) - 16;
      pimm[w] = 32'(off * 4);
      if (r < 55)      begin kind[w] = KOther; imem[w] = enc_addi(12'($urandom)); end
      else if (r < 65) begin kind[w] = KAuipc; imem[w] = enc_auipc(); end
      else if (r < 75) begin kind[w] = KJal;   imem[w] = enc_jal(pimm[w]); end
      else if (r < 93) begin kind[w] = KBr;    imem[w] = enc_b(pimm[w]); end
      else             begin kind[w] = KJalr;  imem[w] = enc_jalr(); end
    end
    wcnt = 0;
    lat  = 1;
    for (int c = 0; c < 4000; c++) begin
      rst          = (c == 0) ? 1'b0 : ($urandom % 300 != 0);
      rdy          = ($urandom % 10 != 0);
      ROB_full     = ($urandom % 12 == 0);
      RS_full      = ($urandom % 12 == 0);
      LSB_full     = ($urandom % 12 == 0);
      ROB_clear    = ($urandom % 30 == 0);
      ROB_newpc    = ($urandom % MemW) * 4;
      ROB_br_sgn   = ($urandom % 4 == 0);
      ROB_br_pc    = ($urandom % MemW) * 4;
      ROB_br_taken = $urandom % 2;
      if (!rdy) begin
        MC_done = $urandom % 2;
        MC_ins  = $urandom;
      end else if (m_mcs) begin
        if (wcnt >= lat) begin
          MC_done = 1'b1;
          MC_ins  = imem[widx(m_mca)];
          wcnt    = 0;
          lat     = $urandom_range(0, 3);
        end else begin
          MC_done = 1'b0;
          wcnt++;
        end
      end else begin
        MC_done = 1'b0;
        wcnt    = 0;
      end
      model_step();
      tick();
      check("random_cycle", {IF_ins_sgn, IF_ins, IF_jump_flag, IF_jump_pc, MC_sgn, MC_addr},
            {m_sgn, m_ins, m_flag, m_jpc, m_mcs, m_mca});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
